// File: rtl/status_led_seq_if.sv
// Status-LED sequencer bus: per-channel mode/code/trigger in,
// LED drive and 1 ms strobe out.
interface status_led_seq_if #(
  parameter int NUM_CH = 6
);
  logic [3*NUM_CH-1:0] i_mode;
  logic [4*NUM_CH-1:0] i_code;
  logic [NUM_CH-1:0]   i_trig;
  logic [NUM_CH-1:0]   o_led;
  logic                o_tick;

  modport master (
    output i_mode, i_code, i_trig,
    input  o_led, o_tick
  );

  modport slave (
    input  i_mode, i_code, i_trig,
    output o_led, o_tick
  );
endinterface

// File: rtl/status_led_seq.sv
// Multi-channel status-LED sequencer on the raw 27 MHz clock:
// off/on/blink/heartbeat, N-pulse blink code and retriggerable one-shot.
module status_led_seq #(
  parameter int NUM_CH     = 6,
  parameter int TICK_DIV   = 27000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int SHOT_MS    = 50
) (
  input logic             i_clk,
  input logic             por_reset_27m,
  status_led_seq_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SHOT_MS > 0) ? $clog2(SHOT_MS + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SHOT_LD = SW'(SHOT_MS);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} cst_e;

  logic [PW-1:0]     pre_q, pre_d;
  logic [9:0]        ms_q, ms_d;
  logic              tick_q, tick_d;
  logic [NUM_CH-1:0] led_q, led_d;

  always_comb begin
    tick_d = 1'b0;
    pre_d  = pre_q + PW'(1);
    ms_d   = ms_q;
    if (pre_q == PRE_MAX) begin
      tick_d = 1'b1;
      pre_d  = '0;
      ms_d   = (ms_q == 10'd999) ? 10'd0 : ms_q + 10'd1;
    end
  end

  always_ff @(posedge i_clk or posedge por_reset_27m) begin
    if (por_reset_27m) begin
      pre_q  <= '0;
      ms_q   <= '0;
      tick_q <= 1'b0;
      led_q  <= {NUM_CH{ACTIVE_LOW}};
    end else begin
      pre_q  <= pre_d;
      ms_q   <= ms_d;
      tick_q <= tick_d;
      led_q  <= led_d;
    end
  end

  assign bus.o_led  = led_q;
  assign bus.o_tick = tick_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cst_e          st_q, st_d;
    logic [2:0]    md, md_q;
    logic [3:0]    code, n_q, n_d, pc_q, pc_d;
    logic [9:0]    tmr_q, tmr_d;
    logic [SW-1:0] shot_q, shot_d;
    logic          trig, chg, lit;

    assign md   = bus.i_mode[3*k +: 3];
    assign code = bus.i_code[4*k +: 4];
    assign trig = bus.i_trig[k];
    assign chg  = (md != md_q);

    always_comb begin
      st_d   = st_q;
      n_d    = n_q;
      pc_d   = pc_q;
      tmr_d  = tmr_q;
      shot_d = shot_q;
      if (chg) begin
        st_d   = S_IDLE;
        pc_d   = '0;
        tmr_d  = '0;
        shot_d = '0;
      end else begin
        if (md == 3'd4) begin
          unique case (st_q)
            S_IDLE: begin
              n_d = code;
              if (code != 4'd0) begin
                st_d  = S_ON;
                pc_d  = 4'd1;
                tmr_d = '0;
              end
            end
            S_ON: if (tick_d) begin
              if (tmr_q == 10'd199) begin
                st_d  = S_OFF;
                tmr_d = '0;
              end else tmr_d = tmr_q + 10'd1;
            end
            S_OFF: if (tick_d) begin
              if (tmr_q == 10'd199) begin
                tmr_d = '0;
                if (pc_q < n_q) begin
                  st_d = S_ON;
                  pc_d = pc_q + 4'd1;
                end else st_d = S_GAP;
              end else tmr_d = tmr_q + 10'd1;
            end
            S_GAP: if (tick_d) begin
              if (tmr_q == 10'd999) begin
                st_d  = S_IDLE;
                tmr_d = '0;
              end else tmr_d = tmr_q + 10'd1;
            end
          endcase
        end
        if (md == 3'd5) begin
          if (trig) shot_d = SHOT_LD;
          else if (tick_d && shot_q != '0)
            shot_d = shot_q - SW'(1);
        end
      end
    end

    // stateful modes go dark in the very cycle their mode changes
    always_comb begin
      lit = 1'b0;
      unique case (1'b1)
        md == 3'd1: lit = 1'b1;
        md == 3'd2: lit = (ms_q < 10'd500);
        md == 3'd3: lit = ((ms_q % 10'd250) < 10'd125);
        md == 3'd4: lit = (st_q == S_ON) && !chg;
        md == 3'd5: lit = (shot_q != '0) && !chg;
        md == 3'd6: lit = (ms_q < 10'd100) ||
                          (ms_q >= 10'd200 && ms_q < 10'd300);
        default:    lit = 1'b0;
      endcase
    end

    assign led_d[k] = lit ^ ACTIVE_LOW;

    always_ff @(posedge i_clk or posedge por_reset_27m) begin
      if (por_reset_27m) begin
        md_q   <= '0;
        st_q   <= S_IDLE;
        n_q    <= '0;
        pc_q   <= '0;
        tmr_q  <= '0;
        shot_q <= '0;
      end else begin
        md_q   <= md;
        st_q   <= st_d;
        n_q    <= n_d;
        pc_q   <= pc_d;
        tmr_q  <= tmr_d;
        shot_q <= shot_d;
      end
    end
  end
endmodule
